freq_meas_ctrl: RTL and testbench
=================================

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50_000_000: preset gate length in clkbz cycles.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000: abort limit in clkbz cycles from start acceptance.
REQ-003 SHALL have parameter CW, default 32: width of the Nx and Ns counters.
REQ-004 SHALL have port clkbz, input, 1 bit: standard reference clock; the only clock in the block.
REQ-005 SHALL have port clr_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port clkx, input, 1 bit: unknown signal, asynchronous to clkbz.
REQ-007 SHALL have port start, input, 1 bit: measurement request.
REQ-008 SHALL have port ack, input, 1 bit: result-consumed acknowledge.
REQ-009 SHALL have port sel, input, 3 bits: byte select; 0-3 select Nx bytes 0..3 (LSB first), 4-7 select Ns bytes 0..3.
REQ-010 SHALL have port out8, output, 8 bits: registered readout byte.
REQ-011 SHALL have port int1, output, 1 bit: result ready.
REQ-012 SHALL have port busy, output, 1 bit: measurement in progress.
REQ-013 SHALL have port gate_out, output, 1 bit: actual (clkx-aligned) gate.
REQ-014 SHALL have port err, output, 1 bit: timeout occurred.
REQ-015 SHALL have port ovf, output, 1 bit: a counter saturated.

Function
REQ-016 SHALL synchronise clkx through two flops plus an edge register, producing a one-cycle pulse xe per clkx rising edge; the supported range is fx < fclkbz/4.
REQ-017 SHALL implement the FSM states IDLE, ARM, MEAS, CLOSE and DONE.
REQ-018 SHALL, in IDLE, on start=1: clear gcnt, tcnt, nx, ns, err and ovf, then enter ARM.
REQ-019 SHALL, while in ARM, MEAS or CLOSE, increment gcnt and tcnt every cycle; gcnt expires on its GATE_CYCLES-th cycle.
REQ-020 SHALL, in ARM, move to MEAS on xe; that edge opens the gate and is not counted; expiry of gcnt in ARM does not close the gate.
REQ-021 SHALL, in MEAS, count every cycle in ns (ns+1) and every xe in nx (nx+1).
REQ-022 SHALL, in MEAS, move to CLOSE in the cycle gcnt expires; an xe in that same cycle is counted.
REQ-023 SHALL, in CLOSE, count every cycle in ns; the first xe increments nx and ns, latches both into result registers, and moves to DONE.
REQ-024 SHALL, when tcnt reaches TIMEOUT_CYCLES in ARM, MEAS or CLOSE, set err=1, latch results as 0, and move to DONE.
REQ-025 SHALL saturate nx and ns at all-ones and set ovf=1 sticky until the next start.
REQ-026 SHALL hold int1=1 throughout DONE.
REQ-027 SHALL, in DONE, on ack=1 go to IDLE next cycle, with int1=0 from that cycle.
REQ-028 SHALL, when start and ack arrive in the same DONE cycle, act on ack only and ignore start.
REQ-029 SHALL ignore start outside IDLE.
REQ-030 SHALL ignore ack outside DONE.
REQ-031 SHALL drive busy=1 in ARM, MEAS and CLOSE.
REQ-032 SHALL drive gate_out=1 in MEAS and CLOSE.
REQ-033 SHALL register out8 from sel with one-cycle latency, always from the latched result registers; results are held through IDLE until overwritten by the next DONE entry.
REQ-034 SHALL give fx = fclkbz * Nx / Ns for external computation; the block performs no division.

Reset
REQ-035 SHALL, on clkbz rising edge with clr_n=0, set state=IDLE.
REQ-036 SHALL, on that reset edge, clear all counters, result registers, synchroniser flops and out8 to 0.
REQ-037 SHALL, on that reset edge, set int1, busy, gate_out, err and ovf to 0.
REQ-038 SHALL let reset mid-measurement abort without any result latch.
REQ-039 SHALL keep all outputs at reset values in the first cycle after clr_n returns high.

Structure
REQ-040 SHALL define the state enum, the sel byte codes and the CW default in package freq_meas_pkg.
REQ-041 SHALL place the synchroniser and edge detector in sub-module x_sync_edge (ports clkbz, clr_n, async_in, edge_out).
REQ-042 SHALL keep FSM, counters and readout mux in freq_meas_ctrl.

Verification (GATE_CYCLES=100, TIMEOUT_CYCLES=1000 unless noted)
REQ-043 SHALL verify nominal: start at cycle 0, xe every 10 cycles from cycle 5 -> gate opens at cycle 5, CLOSE at cycle 100, DONE at cycle 105, Nx=10, Ns=100, int1=1, err=0.
REQ-044 SHALL verify readout: in DONE, sel=0 then 4 -> out8=0x0A one cycle after sel=0, then 0x64 one cycle after sel=4; ack -> int1=0 next cycle, values still readable in IDLE.
REQ-045 SHALL verify timeout: clkx stuck low, start -> DONE at tcnt=1000, err=1, Nx=Ns=0, busy low from the DONE cycle.
REQ-046 SHALL verify simultaneity: xe coinciding with gcnt expiry (xe every 20 from cycle 0; start at cycle 0) -> that edge counted, closes on the next xe; start+ack in DONE -> IDLE, no new measurement.
REQ-047 SHALL verify saturation: CW=8, GATE_CYCLES=300, xe every 4 cycles -> Ns=0xFF, ovf=1.
REQ-048 SHALL verify reset mid-measurement: clr_n low during MEAS for one cycle -> all outputs 0, previous results cleared, and a subsequent start measures correctly.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the reciprocal frequency meter: FSM states,
// readout byte codes and the default counter width.
package freq_meas_pkg;

  localparam int CW_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEAS,
    CLOSE,
    DONE
  } state_t;

  localparam logic [2:0] SEL_NX0 = 3'd0;
  localparam logic [2:0] SEL_NX1 = 3'd1;
  localparam logic [2:0] SEL_NX2 = 3'd2;
  localparam logic [2:0] SEL_NX3 = 3'd3;
  localparam logic [2:0] SEL_NS0 = 3'd4;
  localparam logic [2:0] SEL_NS1 = 3'd5;
  localparam logic [2:0] SEL_NS2 = 3'd6;
  localparam logic [2:0] SEL_NS3 = 3'd7;

  function automatic logic [7:0] pick_byte(input logic [31:0] nx,
                                           input logic [31:0] ns,
                                           input logic [2:0]  sel);
    logic [31:0] w;
    logic [7:0]  b;
    w = (sel >= SEL_NS0) ? ns : nx;
    b = w[7:0];
    case (sel)
      SEL_NX0, SEL_NS0: b = w[7:0];
      SEL_NX1, SEL_NS1: b = w[15:8];
      SEL_NX2, SEL_NS2: b = w[23:16];
      SEL_NX3, SEL_NS3: b = w[31:24];
      default:          b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/x_sync_edge.sv
// Brings the asynchronous clkx into the clkbz domain and emits a one-cycle
// pulse for every rising edge.
module x_sync_edge (
  input  logic clkbz,
  input  logic clr_n,
  input  logic async_in,
  output logic edge_out
);

  logic s1, s2, s3;

  always_ff @(posedge clkbz) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_out = s2 & ~s3;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Reciprocal frequency meter: counts clkx edges (Nx) and clkbz cycles (Ns)
// over a clkx-aligned gate; fx = fclkbz * Nx / Ns is computed externally.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CW             = CW_DEFAULT
) (
  input  logic       clkbz,
  input  logic       clr_n,
  input  logic       clkx,
  input  logic       start,
  input  logic       ack,
  input  logic [2:0] sel,
  output logic [7:0] out8,
  output logic       int1,
  output logic       busy,
  output logic       gate_out,
  output logic       err,
  output logic       ovf
);

  localparam logic [31:0]   G_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [31:0]   T_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t        state;
  logic [31:0]   gcnt, tcnt;
  logic [CW-1:0] nx, ns, res_nx, res_ns, nx_inc, ns_inc;
  logic          xe, nx_full, ns_full, gate_exp, tout;

  x_sync_edge u_sync (
    .clkbz    (clkbz),
    .clr_n    (clr_n),
    .async_in (clkx),
    .edge_out (xe)
  );

  assign nx_full  = &nx;
  assign ns_full  = &ns;
  assign nx_inc   = nx_full ? nx : nx + ONE;
  assign ns_inc   = ns_full ? ns : ns + ONE;
  // >= so a gate opened after gcnt already expired closes straight away
  assign gate_exp = gcnt >= G_LAST;
  assign tout     = tcnt == T_LAST;

  always_ff @(posedge clkbz) begin
    if (!clr_n) begin
      state    <= IDLE;
      gcnt     <= '0;
      tcnt     <= '0;
      nx       <= '0;
      ns       <= '0;
      res_nx   <= '0;
      res_ns   <= '0;
      out8     <= '0;
      int1     <= 1'b0;
      busy     <= 1'b0;
      gate_out <= 1'b0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      out8 <= pick_byte(32'(res_nx), 32'(res_ns), sel);
      if (busy) begin
        gcnt <= gcnt + 32'd1;
        tcnt <= tcnt + 32'd1;
      end
      // busy is high exactly in ARM, MEAS and CLOSE; timeout beats any edge
      if (busy && tout) begin
        state    <= DONE;
        res_nx   <= '0;
        res_ns   <= '0;
        err      <= 1'b1;
        int1     <= 1'b1;
        busy     <= 1'b0;
        gate_out <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            gcnt  <= '0;
            tcnt  <= '0;
            nx    <= '0;
            ns    <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= ARM;
          end
          ARM: if (xe) begin
            state    <= MEAS;
            gate_out <= 1'b1;
          end
          MEAS: begin
            ns  <= ns_inc;
            ovf <= ovf | ns_full | (xe & nx_full);
            if (xe) nx <= nx_inc;
            if (gate_exp) state <= CLOSE;
          end
          CLOSE: begin
            ns  <= ns_inc;
            ovf <= ovf | ns_full | (xe & nx_full);
            if (xe) begin
              nx       <= nx_inc;
              res_nx   <= nx_inc;
              res_ns   <= ns_inc;
              state    <= DONE;
              int1     <= 1'b1;
              busy     <= 1'b0;
              gate_out <= 1'b0;
            end
          end
          DONE: if (ack) begin
            state <= IDLE;
            int1  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: spec vector table, reset/simultaneity sequences and
// randomized measurements checked against an arithmetic gate model.
module tb_freq_meas_ctrl;

  localparam int G    = 100;
  localparam int T    = 1000;
  localparam int G_S  = 300;
  localparam int CW_S = 8;

  typedef struct {
    bit     sat;
    int     f;
    int     p;
    int     o;
    longint nx;
    longint ns;
    bit     er;
    bit     ov;
    int     done;
    bit     both;
  } vec_t;

  logic       clkbz = 1'b0;
  logic       clr_n = 1'b0;
  logic       clkx  = 1'b0;
  logic       start = 1'b0;
  logic       ack   = 1'b0;
  logic [2:0] sel   = 3'd0;
  bit         use_sat = 1'b0;

  logic [7:0] out8_a, out8_b, out8_m;
  logic int1_a, busy_a, gate_a, err_a, ovf_a;
  logic int1_b, busy_b, gate_b, err_b, ovf_b;
  logic int1_m, busy_m, gate_m, err_m, ovf_m;

  int vecs = 0;
  int errs = 0;
  vec_t tbl[5];

  always #5 clkbz = ~clkbz;

  freq_meas_ctrl #(.GATE_CYCLES(G), .TIMEOUT_CYCLES(T), .CW(32)) u_dut (
    .clkbz(clkbz), .clr_n(clr_n), .clkx(clkx), .start(start), .ack(ack), .sel(sel),
    .out8(out8_a), .int1(int1_a), .busy(busy_a), .gate_out(gate_a), .err(err_a), .ovf(ovf_a)
  );

  freq_meas_ctrl #(.GATE_CYCLES(G_S), .TIMEOUT_CYCLES(T), .CW(CW_S)) u_sat (
    .clkbz(clkbz), .clr_n(clr_n), .clkx(clkx), .start(start), .ack(ack), .sel(sel),
    .out8(out8_b), .int1(int1_b), .busy(busy_b), .gate_out(gate_b), .err(err_b), .ovf(ovf_b)
  );

  assign out8_m = use_sat ? out8_b : out8_a;
  assign int1_m = use_sat ? int1_b : int1_a;
  assign busy_m = use_sat ? busy_b : busy_a;
  assign gate_m = use_sat ? gate_b : gate_a;
  assign err_m  = use_sat ? err_b  : err_a;
  assign ovf_m  = use_sat ? ovf_b  : ovf_a;

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkbz);
    #1;
  endtask

  // clkx rising in cycle n shows up as xe in cycle n+2, so rise 2 cycles early
  function automatic bit pat(input int n, input int f, input int p);
    int d;
    if (p == 0) return 1'b0;
    d = n - (f - 2);
    if (d < 0) return 1'b0;
    return (d % p) < 2;
  endfunction

  // Cycle 0 is the start cycle; ARM..CLOSE run from cycle 1, gate expiry is cycle g.
  function automatic vec_t model(input int g, input int t, input int cw,
                                 input int f, input int p);
    vec_t   v;
    longint mx;
    int     o, kc, c;
    mx = (longint'(1) <<< cw) - 1;
    v.sat = 1'b0; v.f = f; v.p = p; v.both = 1'b0;
    v.nx = 0; v.ns = 0; v.er = 1'b1; v.ov = 1'b0; v.done = t + 1; v.o = 1 << 30;
    if (p == 0) return v;
    o = f;
    while (o < 1) o += p;
    if (o >= t) return v;
    v.o = o;
    kc = (g > o + 1) ? g : o + 1;
    c = o;
    while (c <= kc) c += p;
    if (c >= t) return v;
    v.ns = c - o;
    v.nx = (c - o) / p;
    v.ov = (v.nx > mx) || (v.ns > mx);
    if (v.nx > mx) v.nx = mx;
    if (v.ns > mx) v.ns = mx;
    v.er = 1'b0;
    v.done = c + 1;
    return v;
  endfunction

  function automatic logic [7:0] bsel(input vec_t v, input int s);
    longint w;
    w = (s < 4) ? v.nx : v.ns;
    return 8'((w >> (8 * (s % 4))) & 255);
  endfunction

  task automatic run(input vec_t v, input string tag);
    int done_cyc;
    int tbad;
    use_sat = v.sat;
    clkx = 1'b0; start = 1'b0; ack = 1'b0; sel = 3'd0;
    repeat (4) cyc();
    done_cyc = -1;
    tbad = 0;
    for (int n = 0; n < 1200; n++) begin
      if (n > 0) cyc();
      start = (n == 0);
      clkx = pat(n, v.f, v.p);
      @(negedge clkbz);
      if (n > 0 && int1_m === 1'b1) begin
        done_cyc = n;
        break;
      end
      if (n > 0 && (busy_m !== 1'b1 || gate_m !== (n > v.o))) tbad++;
    end
    $display("run %s: f=%0d p=%0d done at cycle %0d (want %0d)", tag, v.f, v.p, done_cyc, v.done);
    check({tag, " done_cycle"}, done_cyc, v.done);
    check({tag, " busy_gate_trace"}, tbad, 0);
    check({tag, " err"}, err_m, v.er);
    check({tag, " ovf"}, ovf_m, v.ov);
    check({tag, " busy_in_done"}, busy_m, 0);
    check({tag, " gate_in_done"}, gate_m, 0);
    clkx = 1'b0;
    for (int s = 0; s < 8; s++) begin
      cyc();
      sel = 3'(s);
      @(negedge clkbz);
      if (s > 0) check({tag, " out8_latency"}, out8_m, bsel(v, s - 1));
      cyc();
      @(negedge clkbz);
      check({tag, $sformatf(" out8_sel%0d", s)}, out8_m, bsel(v, s));
    end
    cyc();
    ack = 1'b1;
    start = v.both;
    @(negedge clkbz);
    check({tag, " int1_before_ack"}, int1_m, 1);
    cyc();
    ack = 1'b0;
    start = 1'b0;
    @(negedge clkbz);
    check({tag, " int1_after_ack"}, int1_m, 0);
    check({tag, " busy_after_ack"}, busy_m, 0);
    if (v.both) begin
      repeat (3) begin
        cyc();
        @(negedge clkbz);
      end
      check({tag, " no_restart"}, busy_m, 0);
    end
    cyc();
    sel = 3'd0;
    cyc();
    @(negedge clkbz);
    check({tag, " idle_readout"}, out8_m, bsel(v, 0));
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " int1"}, int1_a, 0);
    check({nm, " busy"}, busy_a, 0);
    check({nm, " gate"}, gate_a, 0);
    check({nm, " err"},  err_a, 0);
    check({nm, " ovf"},  ovf_a, 0);
    check({nm, " out8"}, out8_a, 0);
  endtask

  initial begin
    // {sat, f, p, open, Nx, Ns, err, ovf, done cycle, start+ack}
    tbl[0] = '{1'b1, 2, 4, 2, 75, 255, 1'b0, 1'b1, 303, 1'b0};
    tbl[1] = '{1'b0, 5, 10, 5, 10, 100, 1'b0, 1'b0, 106, 1'b0};
    tbl[2] = '{1'b0, 0, 20, 20, 5, 100, 1'b0, 1'b0, 121, 1'b1};
    tbl[3] = '{1'b0, 0, 0, 1 << 30, 0, 0, 1'b1, 1'b0, 1001, 1'b0};
    tbl[4] = '{1'b0, 7, 13, 7, 8, 104, 1'b0, 1'b0, 112, 1'b0};

    repeat (3) cyc();
    clr_n = 1'b1;
    @(negedge clkbz);
    check_all_zero("reset_release");
    cyc();
    @(negedge clkbz);
    check_all_zero("reset_release+1");

    for (int i = 0; i < 5; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // reset in the middle of MEAS, then a clean measurement
    use_sat = 1'b0;
    repeat (4) cyc();
    for (int n = 0; n <= 50; n++) begin
      if (n > 0) cyc();
      start = (n == 0);
      clkx = pat(n, 5, 10);
    end
    @(negedge clkbz);
    check("mid_reset gate_before", gate_a, 1);
    cyc();
    clr_n = 1'b0;
    clkx = 1'b0;
    cyc();
    clr_n = 1'b1;
    @(negedge clkbz);
    check_all_zero("mid_reset");
    cyc();
    sel = 3'd4;
    @(negedge clkbz);
    check_all_zero("mid_reset+1");
    cyc();
    @(negedge clkbz);
    check("mid_reset ns_cleared", out8_a, 0);
    run(tbl[1], "after_reset");

    for (int i = 0; i < 8; i++) begin
      int   p, f;
      vec_t v;
      p = int'($urandom_range(25, 4));
      f = int'($urandom_range(p + 1, 2));
      v = model(G, T, 32, f, p);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
